// File: rtl/id_ex_ctrl_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_ctrl_stage
// Brief    : ID/EX control-word register with load-use bubble insertion,
//            flush, downstream stall and a saturating bubble counter.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_ctrl_stage #(
    parameter int WB_W          = 2,
    parameter int MEM_W         = 2,
    parameter int EX_W          = 4,
    parameter int BUBBLE_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [WB_W+MEM_W+EX_W-1:0]  ctrl_i,
    input  logic                        hd_i,
    input  logic                        flush_i,
    input  logic                        stall_i,
    output logic [WB_W-1:0]             wb_o,
    output logic [MEM_W-1:0]            mem_o,
    output logic [EX_W-1:0]             ex_o,
    output logic                        valid_o,
    output logic                        hold_o,
    output logic [CNT_W-1:0]            bubble_cnt_o
);

    // Out-of-range bubble counts are clamped into 1..7.
    localparam int         c_bubbles  = (BUBBLE_CYCLES < 1) ? 1 :
                                        (BUBBLE_CYCLES > 7) ? 7 : BUBBLE_CYCLES;
    localparam logic [2:0] c_rem_init = 3'(c_bubbles - 1);

    localparam logic [0:0] c_st_run    = 1'b0;
    localparam logic [0:0] c_st_bubble = 1'b1;

    logic [WB_W-1:0]  r_wb;
    logic [MEM_W-1:0] r_mem;
    logic [EX_W-1:0]  r_ex;
    logic             r_valid;
    logic [CNT_W-1:0] r_cnt;
    logic [0:0]       r_state;
    logic [2:0]       r_rem;

    logic [CNT_W-1:0] w_cnt_inc;

    assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wb    <= '0;
            r_mem   <= '0;
            r_ex    <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
            r_state <= c_st_run;
            r_rem   <= 3'd0;
        end else if (flush_i) begin
            // A killed instruction is not a hazard bubble, so it is not counted.
            r_wb    <= '0;
            r_mem   <= '0;
            r_ex    <= '0;
            r_valid <= 1'b0;
            r_state <= c_st_run;
            r_rem   <= 3'd0;
        end else if (stall_i) begin
            r_state <= r_state;
        end else if (r_state == c_st_bubble) begin
            r_wb    <= '0;
            r_mem   <= '0;
            r_ex    <= '0;
            r_valid <= 1'b0;
            r_cnt   <= w_cnt_inc;
            r_rem   <= r_rem - 3'd1;
            if (r_rem == 3'd1) begin
                r_state <= c_st_run;
            end
        end else if (hd_i) begin
            r_wb    <= '0;
            r_mem   <= '0;
            r_ex    <= '0;
            r_valid <= 1'b0;
            r_cnt   <= w_cnt_inc;
            if (c_bubbles > 1) begin
                r_state <= c_st_bubble;
                r_rem   <= c_rem_init;
            end
        end else begin
            r_ex    <= ctrl_i[EX_W-1:0];
            r_mem   <= ctrl_i[EX_W +: MEM_W];
            r_wb    <= ctrl_i[EX_W+MEM_W +: WB_W];
            r_valid <= 1'b1;
        end
    end

    assign hold_o       = stall_i | ((r_state == c_st_run) & hd_i) | (r_state == c_st_bubble);
    assign wb_o         = r_wb;
    assign mem_o        = r_mem;
    assign ex_o         = r_ex;
    assign valid_o      = r_valid;
    assign bubble_cnt_o = r_cnt;

endmodule
`default_nettype wire
